// File: rtl/sfp_port_supervisor_if.sv
// rtl/sfp_port_supervisor_if.sv - cage pin, software control and status bundle for the SFP+ port supervisor
interface sfp_port_supervisor_if #(
  parameter int P_PORTS = 1
);
  logic [P_PORTS-1:0]   i_port_enable;
  logic [P_PORTS-1:0]   i_fault_clear;
  logic [P_PORTS-1:0]   i_sfp_los;
  logic [P_PORTS-1:0]   i_sfp_tx_fault;
  logic [P_PORTS-1:0]   i_sfp_mod0_prsnt_n;
  logic [P_PORTS-1:0]   i_xcvr_ready;
  logic [P_PORTS-1:0]   o_sfp_tx_disable;
  logic [P_PORTS-1:0]   o_phy_reset;
  logic [P_PORTS-1:0]   o_link_up;
  logic [P_PORTS-1:0]   o_fault;
  logic [4*P_PORTS-1:0] o_retry_count;

  // master: cage pins and software; slave: the supervisor
  modport master (
    output i_port_enable, i_fault_clear, i_sfp_los, i_sfp_tx_fault,
           i_sfp_mod0_prsnt_n, i_xcvr_ready,
    input  o_sfp_tx_disable, o_phy_reset, o_link_up, o_fault, o_retry_count
  );

  modport slave (
    input  i_port_enable, i_fault_clear, i_sfp_los, i_sfp_tx_fault,
           i_sfp_mod0_prsnt_n, i_xcvr_ready,
    output o_sfp_tx_disable, o_phy_reset, o_link_up, o_fault, o_retry_count
  );
endinterface

// File: rtl/sfp_port_supervisor.sv
// rtl/sfp_port_supervisor.sv - per-cage sequenced SFP+ bring-up with debounce, timed resets, retries and latched fault
module sfp_port_supervisor #(
  parameter int P_PORTS               = 1,
  parameter int P_DEBOUNCE_CYCLES     = 1024,
  parameter int P_TX_DISABLE_CYCLES   = 4096,
  parameter int P_RESET_CYCLES        = 256,
  parameter int P_LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int P_MAX_RETRIES         = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  sfp_port_supervisor_if.slave  bus
);

  localparam int P_MAX_A = (P_TX_DISABLE_CYCLES > P_RESET_CYCLES) ? P_TX_DISABLE_CYCLES : P_RESET_CYCLES;
  localparam int P_MAX_PHASE = (P_MAX_A > P_LOCK_TIMEOUT_CYCLES) ? P_MAX_A : P_LOCK_TIMEOUT_CYCLES;
  localparam int CW = ($clog2(P_MAX_PHASE + 1) > 20) ? $clog2(P_MAX_PHASE + 1) : 20;
  localparam int W_DB = $clog2(P_DEBOUNCE_CYCLES + 1);

  localparam logic [W_DB-1:0] DB_LAST   = W_DB'(P_DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   TXD_LAST  = CW'(P_TX_DISABLE_CYCLES - 1);
  localparam logic [CW-1:0]   RST_LAST  = CW'(P_RESET_CYCLES - 1);
  localparam logic [CW-1:0]   LOCK_LAST = CW'(P_LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      RETRY_MAX = 4'(P_MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ABSENT, ST_TX_OFF, ST_PHY_RST, ST_WAIT_READY, ST_LINK_UP, ST_FAULT
  } state_e;

  for (genvar p = 0; p < P_PORTS; p++) begin : g_port
    // bit order {ready, prsnt_n, tx_fault, los}; safe values until the pins prove otherwise
    logic [3:0]      meta_q, sync_q;
    logic [2:0]      filt_q;
    logic [W_DB-1:0] db_cnt_q [3];

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic            fail;
    logic            txd_q, phy_q, link_q, fault_q;

    logic los_f, txf_f, absent_f, ready_s;
    assign los_f    = filt_q[0];
    assign txf_f    = filt_q[1];
    assign absent_f = filt_q[2];
    assign ready_s  = sync_q[3];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        meta_q <= 4'b0111;
        sync_q <= 4'b0111;
        filt_q <= 3'b111;
        for (int b = 0; b < 3; b++) db_cnt_q[b] <= '0;
      end else begin
        meta_q <= {bus.i_xcvr_ready[p], bus.i_sfp_mod0_prsnt_n[p],
                   bus.i_sfp_tx_fault[p], bus.i_sfp_los[p]};
        sync_q <= meta_q;
        for (int b = 0; b < 3; b++) begin
          if (sync_q[b] == filt_q[b]) begin
            db_cnt_q[b] <= '0;
          end else if (db_cnt_q[b] == DB_LAST) begin
            filt_q[b]   <= sync_q[b];
            db_cnt_q[b] <= '0;
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
          end
        end
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      fail    = 1'b0;
      if (!bus.i_port_enable[p] || absent_f) begin
        state_d = ST_ABSENT;
        retry_d = '0;
      end else begin
        case (state_q)
          ST_ABSENT: state_d = ST_TX_OFF;
          ST_TX_OFF: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == TXD_LAST) state_d = ST_PHY_RST;
          end
          ST_PHY_RST: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == RST_LAST) state_d = ST_WAIT_READY;
          end
          ST_WAIT_READY: begin
            cnt_d = cnt_q + 1'b1;
            // ready in the timeout cycle still wins
            if (ready_s && !los_f && !txf_f) state_d = ST_LINK_UP;
            else if (txf_f || cnt_q == LOCK_LAST) fail = 1'b1;
          end
          ST_LINK_UP: begin
            if (cnt_q != LOCK_LAST) cnt_d = cnt_q + 1'b1;
            if (txf_f) fail = 1'b1;
            else if (los_f || !ready_s) state_d = ST_PHY_RST;
            else if (cnt_q == LOCK_LAST) retry_d = '0;
          end
          ST_FAULT: begin
            if (bus.i_fault_clear[p]) begin
              state_d = ST_TX_OFF;
              retry_d = '0;
            end
          end
          default: state_d = ST_ABSENT;
        endcase
      end
      // re-entering TX_OFF toggles TX_DISABLE, which is the module's TX_FAULT recovery
      if (fail) begin
        retry_d = retry_q + 1'b1;
        state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_TX_OFF;
      end
      if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        state_q <= ST_ABSENT;
        cnt_q   <= '0;
        retry_q <= '0;
        txd_q   <= 1'b1;
        phy_q   <= 1'b1;
        link_q  <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        retry_q <= retry_d;
        txd_q   <= (state_d == ST_ABSENT) || (state_d == ST_TX_OFF) || (state_d == ST_FAULT);
        phy_q   <= (state_d == ST_ABSENT) || (state_d == ST_TX_OFF) ||
                   (state_d == ST_PHY_RST) || (state_d == ST_FAULT);
        link_q  <= (state_d == ST_LINK_UP);
        fault_q <= (state_d == ST_FAULT);
      end
    end

    assign bus.o_sfp_tx_disable[p]   = txd_q;
    assign bus.o_phy_reset[p]        = phy_q;
    assign bus.o_link_up[p]          = link_q;
    assign bus.o_fault[p]            = fault_q;
    assign bus.o_retry_count[4*p +: 4] = retry_q;
  end

endmodule

// File: tb/tb_sfp_port_supervisor.sv
// tb/tb_sfp_port_supervisor.sv - directed scoreboard bench for the two-port SFP+ supervisor
module tb_sfp_port_supervisor;

  logic clk;
  logic rst_n;
  int   cyc;
  int   base;
  int   checks;
  int   failures;

  typedef struct {
    string       tag;
    int          at;
    logic [15:0] v;
  } exp_t;

  exp_t sbq[$];

  sfp_port_supervisor_if #(.P_PORTS(2)) bus();

  sfp_port_supervisor #(
    .P_PORTS               (2),
    .P_DEBOUNCE_CYCLES     (4),
    .P_TX_DISABLE_CYCLES   (8),
    .P_RESET_CYCLES        (4),
    .P_LOCK_TIMEOUT_CYCLES (16),
    .P_MAX_RETRIES         (2)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // edge k = the k-th clock edge after the stimulus, counting the first sampling edge as 0
  task automatic mark();
    base = cyc;
  endtask

  task automatic exp(input string tag, input int k, input logic [1:0] txd, input logic [1:0] phy,
                     input logic [1:0] lnk, input logic [1:0] flt, input logic [7:0] rc);
    exp_t e;
    e.tag = tag;
    e.at  = base + 1 + k;
    e.v   = {txd, phy, lnk, flt, rc};
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] got;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.at > cyc) repeat (e.at - cyc) @(posedge clk);
      #1;
      got = {bus.o_sfp_tx_disable, bus.o_phy_reset, bus.o_link_up, bus.o_fault, bus.o_retry_count};
      checks++;
      assert (got === e.v) else begin
        failures++;
        $error("FAIL %s got={txd,phy,lnk,flt,rc}=%h want=%h", e.tag, got, e.v);
      end
    end
  endtask

  initial begin
    cyc = 0; base = 0; checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.i_port_enable = 2'b00;
    bus.i_fault_clear = 2'b00;
    bus.i_sfp_los = 2'b11;
    bus.i_sfp_tx_fault = 2'b11;
    bus.i_sfp_mod0_prsnt_n = 2'b11;
    bus.i_xcvr_ready = 2'b00;
    step(3);
    mark(); exp("reset", -1, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00); drain();

    rst_n = 1'b1;
    bus.i_port_enable = 2'b11;
    bus.i_sfp_los = 2'b00;
    bus.i_sfp_tx_fault = 2'b00;
    bus.i_xcvr_ready = 2'b11;
    mark(); exp("absent_idle", 9, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00); drain();

    // 3-cycle presence glitch must be rejected
    mark(); bus.i_sfp_mod0_prsnt_n = 2'b10;
    step(3);
    bus.i_sfp_mod0_prsnt_n = 2'b11;
    exp("glitch_a", 6, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("glitch_b", 14, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00);
    drain();

    // clean bring-up on both ports
    mark(); bus.i_sfp_mod0_prsnt_n = 2'b00;
    exp("up_txoff_end", 13, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("up_txd_fall",  14, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("up_phyrst",    17, 2'b00, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("up_phy_fall",  18, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
    exp("up_link",      19, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    drain();

    // LOS on port 0 while linked: PHY reset only, no retry
    mark(); bus.i_sfp_los = 2'b01;
    exp("los_pre",  5, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    exp("los_rst",  6, 2'b00, 2'b01, 2'b10, 2'b00, 8'h00);
    drain();
    mark(); bus.i_sfp_los = 2'b00;
    exp("los_rst_hold", 2, 2'b00, 2'b01, 2'b10, 2'b00, 8'h00);
    exp("los_wait",     3, 2'b00, 2'b00, 2'b10, 2'b00, 8'h00);
    exp("los_wait2",    5, 2'b00, 2'b00, 2'b10, 2'b00, 8'h00);
    exp("los_relink",   6, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    drain();

    // TX_FAULT on port 0 while linked: counted retry, TX_DISABLE toggle
    mark(); bus.i_sfp_tx_fault = 2'b01;
    exp("txf_pre", 5, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    exp("txf_off", 6, 2'b01, 2'b01, 2'b10, 2'b00, 8'h01);
    drain();
    mark(); bus.i_sfp_tx_fault = 2'b00;
    exp("txf_off_end",  6, 2'b01, 2'b01, 2'b10, 2'b00, 8'h01);
    exp("txf_phyrst",   7, 2'b00, 2'b01, 2'b10, 2'b00, 8'h01);
    exp("txf_phyrst2", 10, 2'b00, 2'b01, 2'b10, 2'b00, 8'h01);
    exp("txf_wait",    11, 2'b00, 2'b00, 2'b10, 2'b00, 8'h01);
    exp("txf_relink",  12, 2'b00, 2'b00, 2'b11, 2'b00, 8'h01);
    exp("txf_hold",    27, 2'b00, 2'b00, 2'b11, 2'b00, 8'h01);
    exp("txf_stable",  28, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    drain();

    // ready lost on port 0: two timed-out windows, then FAULT
    mark(); bus.i_xcvr_ready = 2'b10;
    exp("to_still_up",  1, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    exp("to_phyrst",    2, 2'b00, 2'b01, 2'b10, 2'b00, 8'h00);
    exp("to_wait1",     6, 2'b00, 2'b00, 2'b10, 2'b00, 8'h00);
    exp("to_wait1_end",21, 2'b00, 2'b00, 2'b10, 2'b00, 8'h00);
    exp("to_retry1",   22, 2'b01, 2'b01, 2'b10, 2'b00, 8'h01);
    exp("to_txoff_end",29, 2'b01, 2'b01, 2'b10, 2'b00, 8'h01);
    exp("to_phyrst2",  30, 2'b00, 2'b01, 2'b10, 2'b00, 8'h01);
    exp("to_wait2",    34, 2'b00, 2'b00, 2'b10, 2'b00, 8'h01);
    exp("to_wait2_end",49, 2'b00, 2'b00, 2'b10, 2'b00, 8'h01);
    exp("to_fault",    50, 2'b01, 2'b01, 2'b10, 2'b01, 8'h02);
    exp("to_fault_hold",60, 2'b01, 2'b01, 2'b10, 2'b01, 8'h02);
    drain();
    mark(); bus.i_fault_clear = 2'b01; bus.i_xcvr_ready = 2'b11;
    step(1);
    bus.i_fault_clear = 2'b00;
    exp("clr_txoff", 0, 2'b01, 2'b01, 2'b10, 2'b00, 8'h00);
    exp("clr_relink", 13, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    drain();

    // port 1 disabled, re-enabled, then removed during PHY reset; port 0 untouched
    mark(); bus.i_port_enable = 2'b01;
    exp("dis_p1", 0, 2'b10, 2'b10, 2'b01, 2'b00, 8'h00);
    drain();
    mark(); bus.i_port_enable = 2'b11;
    exp("en_p1_txoff", 0, 2'b10, 2'b10, 2'b01, 2'b00, 8'h00);
    exp("en_p1_phyrst", 8, 2'b00, 2'b10, 2'b01, 2'b00, 8'h00);
    drain();
    mark(); bus.i_sfp_mod0_prsnt_n = 2'b10;
    exp("rm_p1_phyrst", 2, 2'b00, 2'b10, 2'b01, 2'b00, 8'h00);
    exp("rm_p1_wait",   3, 2'b00, 2'b00, 2'b01, 2'b00, 8'h00);
    exp("rm_p1_link",   5, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00);
    exp("rm_p1_absent", 6, 2'b10, 2'b10, 2'b01, 2'b00, 8'h00);
    drain();

    // asynchronous reset with port 0 in WAIT_READY
    mark(); bus.i_xcvr_ready = 2'b10;
    exp("pre_rst_phy",  2, 2'b10, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("pre_rst_wait", 6, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00);
    drain();
    rst_n = 1'b0;
    #1;
    mark(); exp("rst_async", -1, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("rst_hold", 2, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00);
    drain();
    bus.i_xcvr_ready = 2'b11;
    rst_n = 1'b1;
    mark();
    exp("rerun_txoff", 13, 2'b11, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("rerun_txd",   14, 2'b10, 2'b11, 2'b00, 2'b00, 8'h00);
    exp("rerun_link",  19, 2'b10, 2'b10, 2'b01, 2'b00, 8'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
